// File: rtl/ahb_reg_slave.sv
// ahb_reg_slave: AHB-Lite responder holding a bank of 32-bit registers.
//
// Sits behind the AHB decoder and returns HREADYOUT/HRESP/HRDATA to the response mux.
// Every OKAY data phase gets WAIT_STATES wait cycles. Byte, halfword and word writes
// are supported. Illegal transfers get the two-cycle ERROR response and leave the
// registers untouched. The whole register bank is exported flat for peripheral logic.
//
// Parameters:
//   AHB_ADDR_WIDTH  HADDR width (bits above [11:0] are ignored)
//   REG_NUM         number of 32-bit registers (power of two, 2..256)
//   WAIT_STATES     wait cycles per OKAY data phase (0..7)
//   RO_MASK         bit i set makes register i read-only (writes answer ERROR)
//
// Ports:
//   ahb_clk_in        clock, rising edge
//   ahb_rst_in        synchronous active-high reset
//   ahb_sel_in        slave select from the decoder
//   ahb_addr_in       HADDR
//   ahb_trans_in      HTRANS (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
//   ahb_write_in      HWRITE
//   ahb_size_in       HSIZE
//   ahb_wdata_in      HWDATA
//   ahb_ready_in      HREADY from the response mux
//   ahb_readyout_out  HREADYOUT
//   ahb_resp_out      HRESP (0 OKAY, 1 ERROR)
//   ahb_rdata_out     HRDATA, zero outside a DATA-state read
//   reg_bank_out      register i on bits [32i+31:32i]
module ahb_reg_slave #(
    parameter int unsigned        AHB_ADDR_WIDTH = 32,
    parameter int unsigned        REG_NUM        = 16,
    parameter int unsigned        WAIT_STATES    = 1,
    parameter logic [REG_NUM-1:0] RO_MASK        = '0
) (
    input  logic                    ahb_clk_in,
    input  logic                    ahb_rst_in,
    input  logic                    ahb_sel_in,
    input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
    input  logic [1:0]              ahb_trans_in,
    input  logic                    ahb_write_in,
    input  logic [2:0]              ahb_size_in,
    input  logic [31:0]             ahb_wdata_in,
    input  logic                    ahb_ready_in,
    output logic                    ahb_readyout_out,
    output logic                    ahb_resp_out,
    output logic [31:0]             ahb_rdata_out,
    output logic [REG_NUM*32-1:0]   reg_bank_out
);

    localparam int unsigned IDX_W     = $clog2(REG_NUM);
    localparam logic [9:0]  REG_LIMIT = 10'(REG_NUM);
    localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StWait = 3'd1;
    localparam logic [2:0] StData = 3'd2;
    localparam logic [2:0] StErr1 = 3'd3;
    localparam logic [2:0] StErr2 = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q;
    logic [1:0]       lo_q;
    logic             write_q;
    logic [1:0]       size_q;

    logic             can_accept;
    logic             accept;
    logic             acc_err;
    logic [IDX_W-1:0] acc_idx;
    logic [9:0]       word_addr;
    logic [3:0]       wstrb;
    logic             commit;

    // The decoder has already qualified the upper address bits.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ahb_addr_in[AHB_ADDR_WIDTH-1:12];

    // A new address phase is only taken while HREADYOUT is high.
    assign can_accept = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
    assign accept     = ahb_sel_in & ahb_ready_in & ahb_trans_in[1] & can_accept;
    assign word_addr  = ahb_addr_in[11:2];
    assign acc_idx    = ahb_addr_in[IDX_W+1:2];

    // RO_MASK lookup is only meaningful in range; out-of-range is an error anyway.
    assign acc_err = (ahb_size_in > 3'd2)
                   | ((ahb_size_in == 3'd1) & ahb_addr_in[0])
                   | ((ahb_size_in == 3'd2) & (ahb_addr_in[1:0] != 2'b00))
                   | (word_addr >= REG_LIMIT)
                   | (ahb_write_in & RO_MASK[acc_idx]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle, StData, StErr2: begin
                if (accept) begin
                    if (acc_err) begin
                        state_d = StErr1;
                    end else if (WAIT_STATES == 0) begin
                        state_d = StData;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WAIT_LOAD;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ahb_clk_in) begin
        if (ahb_rst_in) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            lo_q    <= 2'b00;
            write_q <= 1'b0;
            size_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= acc_idx;
                lo_q    <= ahb_addr_in[1:0];
                write_q <= ahb_write_in;
                size_q  <= ahb_size_in[1:0];
            end
        end
    end

    // Only sizes 0..2 ever reach DATA, so the default arm is the word case.
    always_comb begin
        wstrb = 4'b0000;
        case (size_q)
            2'd0:    wstrb = 4'b0001 << lo_q;
            2'd1:    wstrb = lo_q[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    // Write data is taken from HWDATA during DATA; commits on the edge that ends DATA.
    assign commit = (state_q == StData) & write_q;

    for (genvar g = 0; g < REG_NUM; g++) begin : g_reg
        logic [31:0] reg_q;

        always_ff @(posedge ahb_clk_in) begin
            if (ahb_rst_in) begin
                reg_q <= 32'h0;
            end else if (commit && (idx_q == IDX_W'(g))) begin
                for (int k = 0; k < 4; k++) begin
                    if (wstrb[k]) begin
                        reg_q[8*k +: 8] <= ahb_wdata_in[8*k +: 8];
                    end
                end
            end
        end

        assign reg_bank_out[32*g +: 32] = reg_q;
    end

    assign ahb_readyout_out = !((state_q == StWait) || (state_q == StErr1));
    assign ahb_resp_out     = (state_q == StErr1) || (state_q == StErr2);
    assign ahb_rdata_out    = ((state_q == StData) && !write_q)
                            ? reg_bank_out[{idx_q, 5'd0} +: 32] : 32'h0;

endmodule

// File: tb/tb_ahb_reg_slave.sv
// tb_ahb_reg_slave: self-checking bench for ahb_reg_slave.
// dut0 runs with one wait state and register 3 read-only; dut1 runs with zero wait
// states and register 15 read-only. A per-DUT register array tracks expected contents.
module tb_ahb_reg_slave;

    localparam int          REG_NUM = 16;
    localparam logic [15:0] RO0     = 16'h0008;
    localparam logic [15:0] RO1     = 16'h8000;
    localparam int          WS0     = 1;
    localparam int          WS1     = 0;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                   sel      [2];
    logic [31:0]            addr     [2];
    logic [1:0]             trans    [2];
    logic                   write    [2];
    logic [2:0]             size     [2];
    logic [31:0]            wdata    [2];
    logic                   readyout [2];
    logic                   resp     [2];
    logic [31:0]            rdata    [2];
    logic [REG_NUM*32-1:0]  bank     [2];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [2][REG_NUM];
    op_t         pipe_q[$];

    ahb_reg_slave #(
        .AHB_ADDR_WIDTH(32), .REG_NUM(REG_NUM), .WAIT_STATES(WS0), .RO_MASK(RO0)
    ) dut0 (
        .ahb_clk_in(clk), .ahb_rst_in(rst), .ahb_sel_in(sel[0]), .ahb_addr_in(addr[0]),
        .ahb_trans_in(trans[0]), .ahb_write_in(write[0]), .ahb_size_in(size[0]),
        .ahb_wdata_in(wdata[0]), .ahb_ready_in(readyout[0]), .ahb_readyout_out(readyout[0]),
        .ahb_resp_out(resp[0]), .ahb_rdata_out(rdata[0]), .reg_bank_out(bank[0])
    );

    ahb_reg_slave #(
        .AHB_ADDR_WIDTH(32), .REG_NUM(REG_NUM), .WAIT_STATES(WS1), .RO_MASK(RO1)
    ) dut1 (
        .ahb_clk_in(clk), .ahb_rst_in(rst), .ahb_sel_in(sel[1]), .ahb_addr_in(addr[1]),
        .ahb_trans_in(trans[1]), .ahb_write_in(write[1]), .ahb_size_in(size[1]),
        .ahb_wdata_in(wdata[1]), .ahb_ready_in(readyout[1]), .ahb_readyout_out(readyout[1]),
        .ahb_resp_out(resp[1]), .ahb_rdata_out(rdata[1]), .reg_bank_out(bank[1])
    );

    // ---------------- reference model ----------------
    function automatic bit model_err(input int d, input bit wr, input logic [31:0] a,
                                     input logic [2:0] sz);
        int          idx;
        logic [15:0] ro;
        idx = int'(a[11:2]);
        ro  = (d == 0) ? RO0 : RO1;
        if (sz > 3'd2) return 1'b1;
        if (sz == 3'd1 && a[0]) return 1'b1;
        if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        if (idx >= REG_NUM) return 1'b1;
        if (wr && ro[idx]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                                        input logic [31:0] wd);
        logic [31:0] mask;
        int          idx;
        idx = int'(a[11:2]);
        if (sz == 3'd0)      mask = 32'hFF << (8 * a[1:0]);
        else if (sz == 3'd1) mask = 32'hFFFF << (16 * a[1]);
        else                 mask = 32'hFFFF_FFFF;
        model[d][idx] = (model[d][idx] & ~mask) | (wd & mask);
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < REG_NUM; i++) model[d][i] = 32'h0;
    endfunction

    function automatic logic [REG_NUM*32-1:0] model_bank(input int d);
        logic [REG_NUM*32-1:0] v;
        for (int i = 0; i < REG_NUM; i++) v[32*i +: 32] = model[d][i];
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic idle(input int d);
        sel[d] = 1'b0; trans[d] = 2'd0; addr[d] = 32'h0;
        write[d] = 1'b0; size[d] = 3'd0; wdata[d] = 32'h0;
    endtask

    // One isolated transfer; starts and ends 1 time unit after a rising edge.
    // nlow counts HREADYOUT-low cycles, lowresp holds HRESP seen in each of them.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic fresp,
                        output int nlow, output logic [15:0] lowresp);
        bit done;
        sel[d] = 1'b1; trans[d] = 2'd2; addr[d] = a; write[d] = wr; size[d] = sz;
        wdata[d] = ~wd;
        @(posedge clk); #1;
        sel[d] = 1'b0; trans[d] = 2'd0; addr[d] = $urandom(); write[d] = ~wr; size[d] = 3'd2;
        wdata[d] = wd;
        nlow = 0; lowresp = '0; rd = 32'h0; fresp = 1'bx; done = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            if (readyout[d] === 1'b1) begin
                rd = rdata[d]; fresp = resp[d]; done = 1'b1;
            end else begin
                lowresp[nlow[3:0]] = resp[d];
                nlow++;
            end
            @(posedge clk); #1;
        end
        if (!done) nlow = 99;
        idle(d);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (readyout[d] !== 1'b1) begin
                errors++; $display("FAIL reset_readyout dut%0d: got %b want 1", d, readyout[d]);
            end
            checks++;
            if (resp[d] !== 1'b0) begin
                errors++; $display("FAIL reset_resp dut%0d: got %b want 0", d, resp[d]);
            end
            checks++;
            if (rdata[d] !== 32'h0) begin
                errors++; $display("FAIL reset_rdata dut%0d: got %h want 0", d, rdata[d]);
            end
            checks++;
            if (bank[d] !== '0) begin
                errors++; $display("FAIL reset_bank dut%0d: got %h want 0", d, bank[d]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_word_write();
        logic [31:0] rd; logic fr; int nl; logic [15:0] lr;
        xfer(0, 1'b1, 32'h04, 3'd2, 32'hDEAD_BEEF, rd, fr, nl, lr);
        model_write(0, 32'h04, 3'd2, 32'hDEAD_BEEF);
        checks++;
        if (nl != 1) begin errors++; $display("FAIL word_wait: got %0d low cycles want 1", nl); end
        checks++;
        if (lr !== 16'h0 || fr !== 1'b0) begin
            errors++; $display("FAIL word_resp: got low %h final %b want 0/0", lr, fr);
        end
        checks++;
        if (bank[0][63:32] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL word_reg1: got %h want deadbeef", bank[0][63:32]);
        end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd; logic fr; int nl; logic [15:0] lr;
        xfer(0, 1'b1, 32'h06, 3'd0, 32'h00AB_0000, rd, fr, nl, lr);
        model_write(0, 32'h06, 3'd0, 32'h00AB_0000);
        checks++;
        if (bank[0][63:32] !== 32'hDEAB_BEEF || fr !== 1'b0) begin
            errors++; $display("FAIL byte_reg1: got %h resp %b want deabbeef/0", bank[0][63:32], fr);
        end
        xfer(0, 1'b0, 32'h04, 3'd2, 32'h0, rd, fr, nl, lr);
        checks++;
        if (rd !== 32'hDEAB_BEEF || fr !== 1'b0 || nl != 1) begin
            errors++;
            $display("FAIL byte_readback: got %h resp %b low %0d want deabbeef/0/1", rd, fr, nl);
        end
    endtask

    task automatic test_error_misaligned();
        logic [31:0] rd; logic fr; int nl; logic [15:0] lr;
        xfer(0, 1'b1, 32'h00, 3'd2, 32'h1234_5678, rd, fr, nl, lr);
        model_write(0, 32'h00, 3'd2, 32'h1234_5678);
        xfer(0, 1'b1, 32'h02, 3'd2, 32'hFFFF_FFFF, rd, fr, nl, lr);
        checks++;
        if (nl != 1 || lr !== 16'h1) begin
            errors++; $display("FAIL misalign_err1: got low %0d resp %h want 1/1", nl, lr);
        end
        checks++;
        if (fr !== 1'b1 || rd !== 32'h0) begin
            errors++; $display("FAIL misalign_err2: got resp %b rdata %h want 1/0", fr, rd);
        end
        checks++;
        if (bank[0][31:0] !== 32'h1234_5678) begin
            errors++; $display("FAIL misalign_reg0: got %h want 12345678", bank[0][31:0]);
        end
    endtask

    task automatic test_ro_and_range();
        logic [31:0] rd; logic fr; int nl; logic [15:0] lr;
        xfer(0, 1'b1, 32'h0C, 3'd2, 32'hCAFE_F00D, rd, fr, nl, lr);
        checks++;
        if (nl != 1 || lr !== 16'h1 || fr !== 1'b1 || bank[0][127:96] !== 32'h0) begin
            errors++;
            $display("FAIL ro_write: got low %0d/%h final %b reg3 %h want 1/1/1/0",
                     nl, lr, fr, bank[0][127:96]);
        end
        xfer(0, 1'b1, 32'h40, 3'd2, 32'h5A5A_5A5A, rd, fr, nl, lr);
        checks++;
        if (nl != 1 || lr !== 16'h1 || fr !== 1'b1) begin
            errors++; $display("FAIL range_write: got low %0d/%h final %b want 1/1/1", nl, lr, fr);
        end
        checks++;
        if (bank[0] !== model_bank(0)) begin
            errors++; $display("FAIL range_bank: got %h want %h", bank[0], model_bank(0));
        end
        xfer(0, 1'b0, 32'h0C, 3'd2, 32'h0, rd, fr, nl, lr);
        checks++;
        if (rd !== 32'h0 || fr !== 1'b0 || nl != 1) begin
            errors++; $display("FAIL ro_read: got %h resp %b low %0d want 0/0/1", rd, fr, nl);
        end
    endtask

    task automatic test_back_to_back();
        op_t         op;
        int          n, idx;
        logic [31:0] a, exp;
        pipe_q.delete();
        pipe_q.push_back('{1'b1, 32'h00, 3'd2, 32'd1});
        pipe_q.push_back('{1'b1, 32'h04, 3'd2, 32'd2});
        pipe_q.push_back('{1'b1, 32'h08, 3'd2, 32'd3});
        pipe_q.push_back('{1'b1, 32'h10, 3'd2, 32'd4});
        pipe_q.push_back('{1'b1, 32'h0C, 3'd2, 32'hA5A5_0F0F});
        pipe_q.push_back('{1'b0, 32'h0C, 3'd2, 32'h0});
        pipe_q.push_back('{1'b0, 32'h00, 3'd2, 32'h0});
        pipe_q.push_back('{1'b0, 32'h10, 3'd2, 32'h0});
        // Random tail never writes registers 0,1,2,4 (checked below) or read-only 15.
        for (int k = 0; k < 16; k++) begin
            op.wr = 1'($urandom_range(0, 1));
            if (op.wr) idx = ($urandom_range(0, 3) == 0) ? 3 : int'($urandom_range(5, 14));
            else       idx = int'($urandom_range(0, REG_NUM - 1));
            op.sz = 3'($urandom_range(0, 2));
            a = 32'(idx * 4);
            if (op.sz == 3'd0) a[1:0] = 2'($urandom_range(0, 3));
            if (op.sz == 3'd1) a[1] = 1'($urandom_range(0, 1));
            op.a = a; op.wd = $urandom();
            pipe_q.push_back(op);
        end
        n = pipe_q.size();
        for (int i = 0; i <= n; i++) begin
            checks++;
            if (readyout[1] !== 1'b1 || resp[1] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ready cycle %0d: got %b/%b want 1/0", i, readyout[1], resp[1]);
            end
            if (i > 0) begin
                op = pipe_q[i-1];
                if (!op.wr) begin
                    exp = model[1][int'(op.a[11:2])];
                    checks++;
                    if (rdata[1] !== exp) begin
                        errors++;
                        $display("FAIL b2b_rdata op %0d addr %h: got %h want %h",
                                 i - 1, op.a, rdata[1], exp);
                    end
                end else begin
                    model_write(1, op.a, op.sz, op.wd);
                end
            end
            if (i < n) begin
                sel[1] = 1'b1; trans[1] = (i == 0) ? 2'd2 : 2'd3; addr[1] = pipe_q[i].a;
                write[1] = pipe_q[i].wr; size[1] = pipe_q[i].sz;
            end else begin
                sel[1] = 1'b0; trans[1] = 2'd0;
            end
            wdata[1] = (i > 0) ? pipe_q[i-1].wd : 32'h0;
            @(posedge clk); #1;
        end
        idle(1);
        checks++;
        if (bank[1][31:0] !== 32'd1 || bank[1][63:32] !== 32'd2 || bank[1][95:64] !== 32'd3 ||
            bank[1][159:128] !== 32'd4) begin
            errors++;
            $display("FAIL b2b_regs: got %h %h %h %h want 1 2 3 4", bank[1][31:0],
                     bank[1][63:32], bank[1][95:64], bank[1][159:128]);
        end
        checks++;
        if (bank[1] !== model_bank(1)) begin
            errors++; $display("FAIL b2b_bank: got %h want %h", bank[1], model_bank(1));
        end
    endtask

    task automatic test_reset_mid();
        sel[0] = 1'b1; trans[0] = 2'd2; addr[0] = 32'h08; write[0] = 1'b1; size[0] = 3'd2;
        @(posedge clk); #1;
        idle(0);
        wdata[0] = 32'h5555_AAAA;
        checks++;
        if (readyout[0] !== 1'b0) begin
            errors++; $display("FAIL rstmid_wait: got readyout %b want 0", readyout[0]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (readyout[0] !== 1'b1 || resp[0] !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: got %b/%b want 1/0", readyout[0], resp[0]);
        end
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        checks++;
        if (bank[0][95:64] !== 32'h0 || readyout[0] !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_reg2: got %h ready %b want 0/1", bank[0][95:64], readyout[0]);
        end
        checks++;
        if (bank[0] !== '0 || bank[1] !== '0) begin
            errors++; $display("FAIL rstmid_clear: got %h / %h want 0", bank[0], bank[1]);
        end
        wdata[0] = 32'h0;
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, tmp, exp_rd; logic fr; int nl; logic [15:0] lr;
        logic [2:0]  sz; bit wr, err; int ws;
        for (int d = 0; d < 2; d++) begin
            ws = (d == 0) ? WS0 : WS1;
            for (int it = 0; it < 60; it++) begin
                if ($urandom_range(0, 3) == 0) begin
                    // Cycle that must not be accepted: IDLE/BUSY with select, or NONSEQ without.
                    tmp = $urandom();
                    sel[d] = tmp[0]; trans[d] = tmp[0] ? {1'b0, tmp[1]} : 2'd2;
                    addr[d] = tmp & 32'h3C; write[d] = 1'b1; size[d] = 3'd2; wdata[d] = $urandom();
                    @(posedge clk); #1;
                    idle(d);
                    checks++;
                    if (readyout[d] !== 1'b1 || resp[d] !== 1'b0) begin
                        errors++;
                        $display("FAIL noaccept dut%0d: got %b/%b want 1/0", d, readyout[d], resp[d]);
                    end
                end
                wr = 1'($urandom_range(0, 1));
                a  = 32'($urandom_range(0, 4 * REG_NUM + 7));
                if ($urandom_range(0, 7) == 0) sz = 3'($urandom_range(3, 7));
                else                           sz = 3'($urandom_range(0, 2));
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == 3'd1) a[0] = 1'b0;
                    if (sz == 3'd2) a[1:0] = 2'b00;
                end
                tmp = $urandom(); a[31:12] = tmp[31:12];
                wd  = $urandom();
                err = model_err(d, wr, a, sz);
                exp_rd = (!err && !wr) ? model[d][int'(a[11:2])] : 32'h0;
                xfer(d, wr, a, sz, wd, rd, fr, nl, lr);
                if (!err && wr) model_write(d, a, sz, wd);
                checks++;
                if (nl != (err ? 1 : ws) || lr !== (err ? 16'h1 : 16'h0) || fr !== err) begin
                    errors++;
                    $display("FAIL rand_resp dut%0d wr %0d addr %h size %0d: got low %0d/%h final %b want %0d/%h/%b",
                             d, wr, a, sz, nl, lr, fr, err ? 1 : ws, err ? 16'h1 : 16'h0, err);
                end
                checks++;
                if (rd !== exp_rd) begin
                    errors++;
                    $display("FAIL rand_rdata dut%0d addr %h: got %h want %h", d, a, rd, exp_rd);
                end
                checks++;
                if (bank[d] !== model_bank(d)) begin
                    errors++;
                    $display("FAIL rand_bank dut%0d: got %h want %h", d, bank[d], model_bank(d));
                end
            end
        end
    endtask

    initial begin
        idle(0);
        idle(1);
        rst = 1'b1;
        test_reset();
        test_word_write();
        test_byte_write();
        test_error_misaligned();
        test_ro_and_range();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
